// File: rtl/riscv_uart_pkg.sv
// Shared types and defaults for the riscv_uart_rx receive path.
// The PARITY state is only reachable when RISCV_UART_RX_PARITY_EN is defined.
package riscv_uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } uart_state_t;

   localparam int UART_DATA_W       = 8;
   localparam int UART_CLKS_PER_BIT = 434;

endpackage

// File: rtl/riscv_sync_fifo.sv
// Small synchronous FIFO with registered full/empty flags.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module riscv_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   logic [CNT_W-1:0] count_next;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_comb begin
      count_next = count;
      if (do_push && !do_pop) begin
         count_next = count + 1'b1;
      end else if (!do_push && do_pop) begin
         count_next = count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Flags are derived from the next count so they move in the same cycle as the pointers.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count_next;
         full  <= (count_next == CNT_W'(DEPTH));
         empty <= (count_next == '0);
      end
   end

endmodule

// File: rtl/riscv_uart_rx.sv
// UART receiver answering fixed-latency read requests from the memory stage.
// Define RISCV_UART_RX_PARITY_EN to receive 8E1 frames with an even-parity check.
module riscv_uart_rx
   import riscv_uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 8,
   parameter int DATA_W       = UART_DATA_W
) (
   input  logic              i_riscv_urx_clk,
   input  logic              i_riscv_urx_rst,
   input  logic              i_riscv_urx_rx,
   input  logic              i_riscv_urx_request,
   input  logic              i_riscv_urx_clr_err,
   output logic [DATA_W-1:0] o_riscv_urx_rdata,
   output logic              o_riscv_urx_valid,
   output logic              o_riscv_urx_empty,
   output logic              o_riscv_urx_full,
   output logic              o_riscv_urx_overrun,
   output logic              o_riscv_urx_frame_err,
   output logic              o_riscv_urx_parity_err
);

   localparam int BAUD_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W  = $clog2(DATA_W + 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

   uart_state_t       state;
   logic              rx_meta;
   logic              rx_s;
   logic [BAUD_W-1:0] baud_cnt;
   logic [BIT_W-1:0]  bit_cnt;
   logic [DATA_W-1:0] shift_reg;
   logic              baud_last;
   logic              stop_tick;
   logic              frame_evt;
   logic              push;
   logic              pop;
   logic              overrun_evt;
   logic              fifo_full;
   logic              fifo_empty;
   logic [DATA_W-1:0] fifo_head;

   assign baud_last   = (baud_cnt == BAUD_LAST);
   assign stop_tick   = (state == STOP) && baud_last;
   assign frame_evt   = stop_tick && !rx_s;
   assign pop         = i_riscv_urx_request && !fifo_empty;
   assign overrun_evt = push && fifo_full && !pop;

`ifdef RISCV_UART_RX_PARITY_EN
   logic par_bad;
   logic par_evt;
   logic parity_err;

   assign par_evt = (state == PARITY) && baud_last && (rx_s != ^shift_reg);
   assign push    = stop_tick && rx_s && !par_bad;
   assign o_riscv_urx_parity_err = parity_err;
`else
   assign push    = stop_tick && rx_s;
   assign o_riscv_urx_parity_err = 1'b0;
`endif

   always_ff @(posedge i_riscv_urx_clk) begin
      if (i_riscv_urx_rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= i_riscv_urx_rx;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge i_riscv_urx_clk) begin
      if (i_riscv_urx_rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
`ifdef RISCV_UART_RX_PARITY_EN
         par_bad   <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
`ifdef RISCV_UART_RX_PARITY_EN
               par_bad  <= 1'b0;
`endif
               if (!rx_s) begin
                  state <= START;
               end
            end
            START: begin
               if (baud_cnt == HALF_LAST) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  state    <= rx_s ? IDLE : DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            DATA: begin
               if (baud_last) begin
                  baud_cnt  <= '0;
                  bit_cnt   <= bit_cnt + 1'b1;
                  shift_reg <= {rx_s, shift_reg[DATA_W-1:1]};
                  if (bit_cnt == BIT_LAST) begin
`ifdef RISCV_UART_RX_PARITY_EN
                     state <= PARITY;
`else
                     state <= STOP;
`endif
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`ifdef RISCV_UART_RX_PARITY_EN
            PARITY: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  par_bad  <= par_evt;
                  state    <= STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif
            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  state    <= IDLE;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Every request gets a response next cycle; an empty FIFO answers with zero.
   always_ff @(posedge i_riscv_urx_clk) begin
      if (i_riscv_urx_rst) begin
         o_riscv_urx_rdata     <= '0;
         o_riscv_urx_valid     <= 1'b0;
         o_riscv_urx_overrun   <= 1'b0;
         o_riscv_urx_frame_err <= 1'b0;
`ifdef RISCV_UART_RX_PARITY_EN
         parity_err            <= 1'b0;
`endif
      end else begin
         o_riscv_urx_valid <= i_riscv_urx_request;
         if (i_riscv_urx_request) begin
            o_riscv_urx_rdata <= fifo_empty ? '0 : fifo_head;
         end
         o_riscv_urx_overrun   <= overrun_evt || (o_riscv_urx_overrun && !i_riscv_urx_clr_err);
         o_riscv_urx_frame_err <= frame_evt || (o_riscv_urx_frame_err && !i_riscv_urx_clr_err);
`ifdef RISCV_UART_RX_PARITY_EN
         parity_err            <= par_evt || (parity_err && !i_riscv_urx_clr_err);
`endif
      end
   end

   riscv_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk   (i_riscv_urx_clk),
      .rst   (i_riscv_urx_rst),
      .push  (push),
      .pop   (pop),
      .din   (shift_reg),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign o_riscv_urx_empty = fifo_empty;
   assign o_riscv_urx_full  = fifo_full;

endmodule

// File: tb/tb_riscv_uart_rx.sv
// Directed and randomized bench for riscv_uart_rx against a frame-level queue model.
// Honours RISCV_UART_RX_PARITY_EN to send 11-bit frames with an even-parity bit.
module tb_riscv_uart_rx;

   localparam int CPB   = 16;
   localparam int DEPTH = 8;
`ifdef RISCV_UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int STOP_CYC = 2 + CPB / 2 + CPB * (NBITS - 1);

   logic       clk;
   logic       rst;
   logic       rx;
   logic       request;
   logic       clr_err;
   logic [7:0] rdata;
   logic       valid;
   logic       empty;
   logic       full;
   logic       overrun;
   logic       frame_err;
   logic       parity_err;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0] q[$];
   logic       overrun_m;
   logic       frame_m;
   logic       parity_m;

   riscv_uart_rx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH),
      .DATA_W       (8)
   ) dut (
      .i_riscv_urx_clk        (clk),
      .i_riscv_urx_rst        (rst),
      .i_riscv_urx_rx         (rx),
      .i_riscv_urx_request    (request),
      .i_riscv_urx_clr_err    (clr_err),
      .o_riscv_urx_rdata      (rdata),
      .o_riscv_urx_valid      (valid),
      .o_riscv_urx_empty      (empty),
      .o_riscv_urx_full       (full),
      .o_riscv_urx_overrun    (overrun),
      .o_riscv_urx_frame_err  (frame_err),
      .o_riscv_urx_parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_status(input string tag);
      check({tag, "_empty"}, 32'(empty), 32'(q.size() == 0));
      check({tag, "_full"}, 32'(full), 32'(q.size() == DEPTH));
      check({tag, "_overrun"}, 32'(overrun), 32'(overrun_m));
      check({tag, "_frame_err"}, 32'(frame_err), 32'(frame_m));
      check({tag, "_parity_err"}, 32'(parity_err), 32'(parity_m));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      rx  = 1'b1;
      request = 1'b0;
      clr_err = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      q.delete();
      overrun_m = 1'b0;
      frame_m   = 1'b0;
      parity_m  = 1'b0;
   endtask

   // Drives one frame bit-by-bit; optional request on the stop-sample cycle or reset mid-frame.
   task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic flip_par,
                             input bit req_at_stop, input bit check_push, input int abort_cyc);
      logic [10:0] fr;
      logic [7:0]  head_exp;
      bit          good;
      fr = '1;
      fr[0] = 1'b0;
      fr[8:1] = data;
      head_exp = 8'h00;
`ifdef RISCV_UART_RX_PARITY_EN
      fr[9]  = (^data) ^ flip_par;
      fr[10] = stop_bit;
      good   = stop_bit && !flip_par;
`else
      fr[9]  = stop_bit;
      good   = stop_bit;
`endif
      for (int cyc = 0; cyc < NBITS * CPB; cyc++) begin
         if (cyc == abort_cyc) begin
            do_reset();
            return;
         end
         if (check_push && cyc == STOP_CYC) check("empty_before_push", 32'(empty), 32'd1);
         if (check_push && cyc == STOP_CYC + 1) check("empty_after_push", 32'(empty), 32'd0);
         if (req_at_stop && cyc == STOP_CYC + 1) begin
            check("stop_req_valid", 32'(valid), 32'd1);
            check("stop_req_rdata", 32'(rdata), 32'(head_exp));
         end
         rx = fr[cyc / CPB];
         request = req_at_stop && (cyc == STOP_CYC);
         if (req_at_stop && cyc == STOP_CYC) head_exp = (q.size() != 0) ? q.pop_front() : 8'h00;
         tick();
      end
      request = 1'b0;
      rx = 1'b1;
      if (!stop_bit) frame_m = 1'b1;
`ifdef RISCV_UART_RX_PARITY_EN
      if (flip_par) parity_m = 1'b1;
`endif
      if (good) begin
         if (q.size() < DEPTH) q.push_back(data);
         else overrun_m = 1'b1;
      end
      repeat (4) tick();
   endtask

   // Issues n back-to-back requests and checks each one-cycle-later response.
   task automatic do_reads(input int n, input string tag);
      logic [7:0] exp;
      for (int i = 0; i < n; i++) begin
         request = 1'b1;
         exp = (q.size() != 0) ? q.pop_front() : 8'h00;
         tick();
         check({tag, "_valid"}, 32'(valid), 32'd1);
         check({tag, "_rdata"}, 32'(rdata), 32'(exp));
      end
      request = 1'b0;
      tick();
      check({tag, "_valid_drop"}, 32'(valid), 32'd0);
      check({tag, "_rdata_hold"}, 32'(rdata), 32'(exp));
   endtask

   task automatic pulse_clr();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      overrun_m = 1'b0;
      frame_m   = 1'b0;
      parity_m  = 1'b0;
   endtask

   initial begin
      logic [7:0] b;
      rst = 1'b1;
      rx  = 1'b1;
      request = 1'b0;
      clr_err = 1'b0;
      q.delete();
      overrun_m = 1'b0;
      frame_m   = 1'b0;
      parity_m  = 1'b0;
      repeat (3) tick();
      check("reset_rdata", 32'(rdata), 32'd0);
      check("reset_valid", 32'(valid), 32'd0);
      check_status("reset");
      rst = 1'b0;
      repeat (3) tick();

      $display("[TB] single frame 0xA5");
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1, -1);
      check_status("after_a5");
      do_reads(1, "read_a5");
      check_status("drained_a5");

      $display("[TB] read while empty");
      do_reads(1, "read_empty");
      check_status("after_empty_read");

      $display("[TB] overflow with nine frames");
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0, 1'b0, -1);
      check_status("overflow");
      do_reads(8, "drain_overflow");
      check_status("drained_overflow");
      pulse_clr();
      check_status("overrun_cleared");

      $display("[TB] framing error and glitch");
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, -1);
      repeat (20) tick();
      check_status("frame_err");
      pulse_clr();
      rx = 1'b0;
      repeat (4) tick();
      rx = 1'b1;
      repeat (40) tick();
      check_status("glitch");
      b = 8'($urandom);
      send_frame(b, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      do_reads(1, "after_glitch");

      $display("[TB] full FIFO with pop on stop sample");
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, -1);
      check_status("prefill");
      send_frame(8'h77, 1'b1, 1'b0, 1'b1, 1'b0, -1);
      check_status("push_pop_full");
      do_reads(DEPTH, "drain_full");
      check_status("drained_full");

      $display("[TB] reset mid-frame");
      send_frame(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, CPB * 4 + 3);
      check_status("mid_reset");
      repeat (5) tick();
      send_frame(8'h12, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      do_reads(2, "after_mid_reset");

      $display("[TB] random traffic");
      for (int i = 0; i < 10; i++) begin
         send_frame(8'($urandom), 1'b1, 1'b0, 1'b0, 1'b0, -1);
         repeat ($urandom_range(0, 20)) tick();
         if ($urandom_range(0, 1) == 1) do_reads($urandom_range(1, 3), "random_read");
      end
      check_status("random");
      do_reads(DEPTH + 1, "random_drain");

`ifdef RISCV_UART_RX_PARITY_EN
      $display("[TB] parity error");
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, -1);
      check_status("parity_err");
      pulse_clr();
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, -1);
      do_reads(1, "parity_good");
`endif

      check_status("final");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
